// File: rtl/pcs_chain_sequencer_if.sv
// pcs_chain_sequencer_if: run-control and status bundle between the PCS chain sequencer and its controller
interface pcs_chain_sequencer_if #(parameter int NB_COUNT = 16);
  logic                i_start;
  logic                i_stop;
  logic [NB_COUNT-1:0] i_num_blocks;
  logic                i_bypass_req;
  logic                o_enable_encoder;
  logic                o_enable_scrambler;
  logic                o_enable_descrambler;
  logic                o_enable_decoder;
  logic                o_bypass;
  logic                o_rx_valid;
  logic                o_busy;
  logic                o_done;
  logic [NB_COUNT-1:0] o_block_count;
  modport master (
    output i_start, i_stop, i_num_blocks, i_bypass_req,
    input  o_enable_encoder, o_enable_scrambler, o_enable_descrambler, o_enable_decoder,
    input  o_bypass, o_rx_valid, o_busy, o_done, o_block_count
  );
  modport slave (
    input  i_start, i_stop, i_num_blocks, i_bypass_req,
    output o_enable_encoder, o_enable_scrambler, o_enable_descrambler, o_enable_decoder,
    output o_bypass, o_rx_valid, o_busy, o_done, o_block_count
  );
endinterface

// File: rtl/pcs_chain_sequencer.sv
// pcs_chain_sequencer: staged enable sequencing for the TX->RX PCS loopback chain
module pcs_chain_sequencer #(
  parameter int ENC_LAT  = 2,
  parameter int SCR_LAT  = 1,
  parameter int DESC_LAT = 1,
  parameter int DEC_LAT  = 2,
  parameter int NB_COUNT = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  pcs_chain_sequencer_if.slave  bus
);
  localparam int L = ENC_LAT + SCR_LAT + DESC_LAT + DEC_LAT;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t              r_state, w_next;
  logic [L-1:0]        r_dl;
  logic [NB_COUNT-1:0] r_n, r_count, w_count_inc;
  logic                r_bypass, w_enc, w_last;
  assign w_count_inc = r_count + NB_COUNT'(1);
  assign w_last      = (r_n != '0) && (w_count_inc == r_n);
  // State, run parameters, block counter and the single tapped enable delay line
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_dl     <= '0;
      r_n      <= '0;
      r_count  <= '0;
      r_bypass <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dl    <= {r_dl[L-2:0], w_enc};
      if (r_state == S_IDLE && bus.i_start) begin
        r_n      <= bus.i_num_blocks;
        r_bypass <= bus.i_bypass_req;
        r_count  <= '0;
      end
      if (r_state == S_RUN) r_count <= w_count_inc;
    end
  end
  // Next state; drain ends one cycle early so DONE lands right after the last rx_valid
  always_comb begin
    w_enc  = (r_state == S_RUN);
    w_next = (r_state == S_IDLE)  ? (bus.i_start ? S_RUN : S_IDLE) :
             (r_state == S_RUN)   ? ((w_last || bus.i_stop) ? S_DRAIN : S_RUN) :
             (r_state == S_DRAIN) ? ((r_dl[L-2:0] == '0) ? S_DONE : S_DRAIN) :
                                    S_IDLE;
  end
  assign bus.o_enable_encoder     = w_enc;
  assign bus.o_enable_scrambler   = r_dl[ENC_LAT-1];
  assign bus.o_enable_descrambler = r_dl[ENC_LAT+SCR_LAT-1];
  assign bus.o_enable_decoder     = r_dl[ENC_LAT+SCR_LAT+DESC_LAT-1];
  assign bus.o_rx_valid           = r_dl[L-1];
  assign bus.o_bypass             = r_bypass;
  assign bus.o_busy               = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.o_done               = (r_state == S_DONE);
  assign bus.o_block_count        = r_count;
endmodule

// File: tb/tb_pcs_chain_sequencer.sv
// tb_pcs_chain_sequencer: vector table, directed corner sequences and random run against a timing model
module tb_pcs_chain_sequencer;
  localparam int ENC_LAT = 2, SCR_LAT = 1, DESC_LAT = 1, DEC_LAT = 2, NB = 16;
  localparam int L = ENC_LAT + SCR_LAT + DESC_LAT + DEC_LAT;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pcs_chain_sequencer_if #(.NB_COUNT(NB)) bus ();
  pcs_chain_sequencer #(.ENC_LAT(ENC_LAT), .SCR_LAT(SCR_LAT), .DESC_LAT(DESC_LAT),
                        .DEC_LAT(DEC_LAT), .NB_COUNT(NB))
    dut (.i_clock(clk), .i_reset(rst), .bus(bus));
  typedef struct {
    bit          rst, start, stop;
    logic [15:0] nb;
    bit          byp;
    logic [6:0]  exp;
    logic [15:0] cnt;
  } vec_t;
  vec_t tv[12];
  int checks = 0, errors = 0;
  bit m_run, m_byp;
  int m_cnt, m_n, m_done, e;
  bit h[256];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, e, act, exp);
    end
  endtask
  function automatic logic [23:0] dut_vec();
    return {bus.o_enable_encoder, bus.o_enable_scrambler, bus.o_enable_descrambler,
            bus.o_enable_decoder, bus.o_rx_valid, bus.o_bypass, bus.o_busy, bus.o_done,
            bus.o_block_count};
  endfunction
  function automatic bit hist(input int d);
    return (e >= d) ? h[(e - d) & 255] : 1'b0;
  endfunction
  function automatic logic [23:0] model_vec();
    return {m_run, hist(ENC_LAT), hist(ENC_LAT + SCR_LAT), hist(ENC_LAT + SCR_LAT + DESC_LAT),
            hist(L), m_byp, m_run || (e < m_done), e == m_done, 16'(m_cnt)};
  endfunction
  task automatic model_step(input bit r, s, p, input logic [15:0] n, input bit b);
    bit idle;
    e++;
    if (r) begin
      m_run = 0; m_byp = 0; m_cnt = 0; m_done = -1000;
      foreach (h[i]) h[i] = 0;
    end else begin
      idle = !m_run && (e >= m_done + 2);
      if (m_run) begin
        m_cnt = (m_cnt + 1) % 65536;
        if ((m_n != 0 && m_cnt == m_n) || p) begin
          m_run  = 0;
          m_done = e + L;
        end
      end else if (idle && s) begin
        m_run = 1; m_n = int'(n); m_byp = b; m_cnt = 0;
      end
    end
    h[e & 255] = m_run;
  endtask
  task automatic tick(input bit r, s, p, input logic [15:0] n, input bit b);
    rst = r; bus.i_start = s; bus.i_stop = p; bus.i_num_blocks = n; bus.i_bypass_req = b;
    @(posedge clk);
    model_step(r, s, p, n, b);
    #1;
    check("cycle", 32'(dut_vec()), 32'(model_vec()));
  endtask
  task automatic apply_table(input int first);
    for (int i = first; i < 12; i++) begin
      tick(tv[i].rst, tv[i].start, tv[i].stop, tv[i].nb, tv[i].byp);
      check("table", {9'd0, bus.o_enable_encoder, bus.o_enable_scrambler, bus.o_enable_descrambler,
                      bus.o_enable_decoder, bus.o_rx_valid, bus.o_busy, bus.o_done, bus.o_block_count},
                     {9'd0, tv[i].exp, tv[i].cnt});
    end
  endtask
  initial begin
    int rx_n, done_e, rise_e;
    bus.i_start = 0; bus.i_stop = 0; bus.i_num_blocks = '0; bus.i_bypass_req = 0;
    m_run = 0; m_byp = 0; m_cnt = 0; m_n = 0; m_done = -1000; e = 0;
    tv[0]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 7'b0000000, 16'd0};
    tv[1]  = '{1'b0, 1'b1, 1'b0, 16'd3, 1'b0, 7'b1000010, 16'd0};
    tv[2]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 7'b1000010, 16'd1};
    tv[3]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 7'b1100010, 16'd2};
    tv[4]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 7'b0110010, 16'd3};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 7'b0111010, 16'd3};
    tv[6]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 7'b0011010, 16'd3};
    tv[7]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 7'b0001110, 16'd3};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 7'b0000110, 16'd3};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 7'b0000110, 16'd3};
    tv[10] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 7'b0000001, 16'd3};
    tv[11] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 7'b0000000, 16'd3};
    tick(1, 0, 0, 0, 0);
    apply_table(0);
    tick(0, 1, 0, 16'd0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 16'd7, 0);
    tick(0, 0, 1, 16'd0, 0);
    check("stop_count", 32'(bus.o_block_count), 32'd5);
    rx_n = 0; done_e = -1;
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 16'd0, 0);
      rx_n += int'(bus.o_rx_valid);
      if (bus.o_done) done_e = i;
    end
    check("stop_rx_cycles", 32'(rx_n), 32'd5);
    check("stop_done_pos", 32'(done_e), 32'd5);
    tick(0, 1, 0, 16'd1, 1);
    rx_n = 0;
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 0, 16'd9, i[0]);
      rx_n += int'(bus.o_rx_valid);
    end
    check("n1_rx_cycles", 32'(rx_n), 32'd1);
    check("n1_bypass_held", 32'(bus.o_bypass), 32'd1);
    tick(0, 1, 0, 16'd10, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 16'd10, 0);
    tick(1, 0, 0, 16'd10, 0);
    check("reset_abort", 32'(dut_vec()), 32'd0);
    apply_table(1);
    done_e = -1; rise_e = -1;
    for (int i = 0; i < 30; i++) begin
      tick(0, 1, 0, 16'd2, 0);
      if (bus.o_done && done_e < 0) done_e = i;
      if (done_e >= 0 && rise_e < 0 && bus.o_enable_encoder) rise_e = i;
    end
    check("restart_gap", 32'(rise_e - done_e), 32'd2);
    for (int i = 0; i < 12; i++) tick(0, 0, 0, 16'd2, 0);
    tick(0, 0, 1, 16'd2, 0);
    check("idle_stop_ignored", 32'(bus.o_busy), 32'd0);
    tick(0, 1, 1, 16'd2, 0);
    for (int i = 0; i < 12; i++) tick(0, 0, 0, 16'd0, 0);
    check("start_stop_full_n", 32'(bus.o_block_count), 32'd2);
    tick(0, 1, 0, 16'd0, 0);
    for (int i = 0; i < 65536; i++) tick(0, 0, 0, 16'd0, 0);
    check("wrap_zero", 32'(bus.o_block_count), 32'd0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 16'd0, 0);
    tick(0, 0, 1, 16'd0, 0);
    check("wrap_after", 32'(bus.o_block_count), 32'd5);
    for (int i = 0; i < 12; i++) tick(0, 0, 0, 16'd0, 0);
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
           16'($urandom_range(0, 6)), 1'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pcs_chain_sequencer.md
Name: pcs_chain_sequencer

Overview:
- Run controller for the TX→RX PCS loopback chain: encoder (comparator+FSM), scrambler, descrambler, decoder (comparator+fsm interface+FSM).
- Generates the four stage enables so each stage turns on only when valid data reaches it and turns off only after its last valid block has passed through.
- Runs either a bounded burst of N blocks or runs free until stopped.
- Latches bypass for the whole run and reports busy/done/valid status to the testbench or top-level.

Parameters:
ENC_LAT, 2, cycles from encoder enable to first valid coded block at encoder FSM output (≥1)
SCR_LAT, 1, scrambler input-to-output latency in cycles (≥1)
DESC_LAT, 1, descrambler input-to-output latency in cycles (≥1)
DEC_LAT, 2, decoder input-to-raw-output latency in cycles (≥1)
NB_COUNT, 16, width of the block-count request and counter

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_start  in  1  start a run; sampled only in IDLE
i_stop  in  1  end an unbounded or bounded run early; sampled only in RUN
i_num_blocks  in  NB_COUNT  burst length, latched at start; 0 = unbounded
i_bypass_req  in  1  scrambler/descrambler bypass request, latched at start
o_enable_encoder  out  1  drives encoder ROMs, comparator and FSM enable
o_enable_scrambler  out  1  scrambler enable
o_enable_descrambler  out  1  descrambler enable
o_enable_decoder  out  1  decoder comparator, interface and FSM enable
o_bypass  out  1  latched bypass to scrambler/descrambler
o_rx_valid  out  1  decoder raw outputs carry a valid block
o_busy  out  1  high in RUN and DRAIN
o_done  out  1  one-cycle pulse at end of run
o_block_count  out  NB_COUNT  encoder-enabled cycles in the current/last run

Behaviour:
- Reset (synchronous): state=IDLE. All enables, o_rx_valid, o_busy, o_done=0. o_bypass=0, o_block_count=0. All delay lines cleared. Applies mid-run and aborts it with no drain.
- Delay lines: let L=ENC_LAT+SCR_LAT+DESC_LAT+DEC_LAT.
  - scr_en = enc_en delayed ENC_LAT.
  - desc_en = scr_en delayed SCR_LAT.
  - dec_en = desc_en delayed DESC_LAT.
  - rx_valid = dec_en delayed DEC_LAT.
  - Implement as shift registers. Every pulse pattern propagates exactly, including gaps.
- States:
  - IDLE: i_start=1 at edge t → RUN. Latch i_num_blocks→N and i_bypass_req→o_bypass; clear o_block_count. enc_en=1 from t+1.
  - RUN: enc_en=1 and o_block_count increments each cycle. Counter wraps modulo 2^NB_COUNT when N=0.
    - Go to DRAIN next cycle when (N≠0 and count reaches N after this increment) or i_stop=1.
    - The cycle in which stop is sampled is still enabled and counted.
  - DRAIN: enc_en=0. Wait until all delay-line stages and rx_valid are 0, then go to DONE.
  - DONE: o_done=1 for exactly one cycle → IDLE. o_bypass holds its value until the next start.
- Bounded run, start at t: encoder high t+1..t+N; scrambler t+1+ENC_LAT..t+N+ENC_LAT; rx_valid t+1+L..t+N+L; o_done at t+N+L+1; o_busy t+1..t+N+L.
- Start/stop priority:
  - i_start outside IDLE: ignored.
  - i_stop outside RUN: ignored.
  - i_start and i_stop in the same IDLE cycle: run starts, stop discarded.
  - Stop in the same cycle the count reaches N: single transition to DRAIN.
- i_bypass_req and i_num_blocks changes during a run: no effect.
- N=1: exactly one encoder-enabled cycle.

Test Plan:
- Defaults (L=6), reset, start at t with N=3 → enc 1 at t+1..t+3; scr t+3..t+5; desc t+4..t+6; dec t+5..t+7; rx_valid t+7..t+9; o_done only at t+10; o_block_count=3.
- N=0 start, i_stop at t+5 → enc high t+1..t+5; o_block_count=5; rx_valid t+7..t+11; o_done at t+12.
- N=1 with i_bypass_req=1 at start, toggled during run → o_bypass=1 throughout run and after; exactly one rx_valid cycle at t+7.
- i_reset at t+4 in a N=10 run → next cycle all outputs 0, state IDLE; subsequent start behaves like the first scenario.
- i_start held high continuously with N=2 → second run starts only in the cycle after o_done; i_stop in IDLE ignored; start+stop in the same IDLE cycle runs the full N.
- N=0 run longer than 65536 cycles, then stop → o_block_count wraps to 0 at 65536 and keeps counting; drain and done behave normally.
